// File: rtl/display_pkg.sv
// display_pkg: shared types, constants and the round-robin successor search for the digit scanner.
package display_pkg;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
  typedef struct packed {
    logic       wrap;
    logic [2:0] idx;
  } nxt_t;
  // First enabled index strictly after cur (mod n); wrap when it is not above cur.
  function automatic nxt_t next_enabled(input logic [7:0] en, input logic [2:0] cur, input int n);
    nxt_t r;
    logic [2:0] j;
    r.idx = cur;
    for (int k = 8; k >= 1; k--) begin
      j = 3'((int'(cur) + k) % n);
      if (k <= n && en[j]) r.idx = j;
    end
    r.wrap = r.idx <= cur;
    return r;
  endfunction
endpackage

// File: rtl/display.sv
// display: hex nibble to active-low seven-segment pattern, bit order gfedcba.
module display (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: round-robin multiplexed scan of seven-segment digits with blanking gaps.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int DWELL_COUNT = 2400,
  parameter int BLANK_COUNT = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic [2:0]              cur_digit,
  output logic                    frame_tick
);
  localparam int MAXC = DWELL_COUNT > BLANK_COUNT ? DWELL_COUNT : BLANK_COUNT;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;

  scan_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            cur_q, cur_d, nxt_q, nxt_d, base;
  logic [6:0]            seg_q, seg_d, dec;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  tick_q, tick_d, show;
  logic [7:0]            en8;
  logic [31:0]           data32;
  logic [3:0]            nib;
  nxt_t                  succ;

  assign en8    = 8'(digit_en);
  assign data32 = 32'(digit_data);
  // From IDLE the search starts just below index 0, yielding the lowest enabled digit.
  assign base   = state_q == IDLE ? 3'(NUM_DIGITS - 1) : cur_q;
  assign succ   = next_enabled(en8, base, NUM_DIGITS);

  display u_dec (.hex(nib), .seg(dec));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= '1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    tick_d  = 1'b0;
    if (digit_en == '0) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      cnt_d   = '0;
      nxt_d   = succ.idx;
    end else if (state_q == BLANK && cnt_q == CW'(BLANK_COUNT - 1)) begin
      state_d = SHOW;
      cnt_d   = '0;
      cur_d   = nxt_q;
    end else if (state_q == SHOW && (!en8[cur_q] || cnt_q == CW'(DWELL_COUNT - 1))) begin
      state_d = BLANK;
      cnt_d   = '0;
      nxt_d   = succ.idx;
      tick_d  = succ.wrap;
    end
  end

  // A digit whose enable has dropped is never driven, even in the cycle it aborts.
  always_comb begin
    show  = state_q == SHOW && en8[cur_q];
    nib   = data32[{cur_q, 2'b00} +: 4];
    seg_d = show ? dec : SEG_OFF;
    sel_d = show ? ~(NUM_DIGITS'(1) << cur_q) : '1;
  end

  assign seg         = seg_q;
  assign digit_sel_n = sel_q;
  assign cur_digit   = cur_q;
  assign frame_tick  = tick_q;
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for N common-anode seven-segment digits sharing one segment bus.
- Sequences the digits round-robin and decodes the selected digit's 4-bit hex value to segments.
- Inserts a blanking gap between digits to suppress ghosting and skips disabled digits.
- Sits between the switch/data sources and the display pins; replaces the free-running divided-clock mux in the top level.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; legal range 2..8.
- DWELL_COUNT, 2400, clk cycles each digit is driven per visit; must be >= 1.
- BLANK_COUNT, 48, clk cycles all digits are off between visits; must be >= 1.

Ports:
- clk  input  1  system clock, 48 MHz from HSOSC.
- reset  input  1  asynchronous, active-low reset.
- digit_en  input  NUM_DIGITS  per-digit enable; bit i = digit i participates in the scan.
- digit_data  input  4*NUM_DIGITS  hex value per digit; digit i occupies bits [4i+3:4i].
- seg  output  7  active-low segments, registered.
- digit_sel_n  output  NUM_DIGITS  active-low digit drive, one-hot-low or all ones, registered.
- cur_digit  output  3  index of the digit in SHOW, or of the last shown digit; registered.
- frame_tick  output  1  one-cycle pulse when the scan wraps to a lower or equal index.

Behaviour:
- Reset (async assert, sync release): state=IDLE, seg=7'b1111111, digit_sel_n=all ones, cur_digit=0, frame_tick=0, counter=0.
- States: IDLE, BLANK, SHOW.
- IDLE: outputs off. When digit_en != 0, pick the lowest enabled index as next and go to BLANK.
- BLANK: seg and digit_sel_n are all ones for exactly BLANK_COUNT cycles, then go to SHOW on the chosen next index.
- SHOW: digit_sel_n[cur_digit]=0 and seg=decode(digit_data[cur_digit]) for exactly DWELL_COUNT cycles.
  - At the end of SHOW, select the next enabled index strictly after cur_digit, wrapping modulo NUM_DIGITS, then go to BLANK.
  - If the next index is <= cur_digit, pulse frame_tick in the cycle BLANK is entered.
- Single enabled digit: it alternates SHOW/BLANK with itself, and frame_tick fires every visit.
- Output latency: registered outputs lag state by 1 cycle. A digit_data change during SHOW appears on seg 1 cycle later.
- digit_en changes:
  - Re-sampled only at SHOW end, except for the two cases below.
  - If the current digit's enable drops mid-SHOW, abort to BLANK next cycle with a full BLANK_COUNT.
  - If digit_en becomes 0 in any state, go to IDLE next cycle, with outputs off 1 cycle later.
- Only one digit_sel_n bit is ever low. A BLANK of at least BLANK_COUNT cycles always separates two different driven digits, including after an abort.
- Counter: width clog2(max(DWELL_COUNT, BLANK_COUNT)); cleared on every state entry; never wraps mid-state.
- Decode: 0-F hex to active-low segments, matching the existing `display` encoding (A-F shown as A b C d E F).
- Reset mid-SHOW: outputs go off immediately (asynchronous); the scan restarts from IDLE.

Decomposition:
- Package display_pkg:
  - SEG_OFF = 7'b1111111.
  - scan_state_t enum {IDLE, BLANK, SHOW}.
  - Function next_enabled(en, cur) returning the round-robin successor index and a wrap flag.
- Sub-module: reuse the existing `display` hex-to-seven-segment decoder, instantiated once on the muxed nibble.
- The state machine, counter and output registers stay in display_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=2, DWELL_COUNT=4, BLANK_COUNT=2.
1. Reset release with digit_en=2'b11, data {4'hA, 4'h3} -> IDLE 1 cycle, off 2 cycles, then digit_sel_n=2'b10 with seg=7'b0110000 ('3') for 4 cycles, off 2, then 2'b01 with seg='A' for 4. frame_tick pulses once per wrap to digit 0; period 12 cycles.
2. digit_en=2'b10 only -> digit 1 driven 4 of every 6 cycles, digit_sel_n never 2'b10, frame_tick every 6 cycles.
3. During digit 0 SHOW cycle 2, clear digit_en[0] -> all off next cycle, 2 blank cycles, then digit 1 driven for 4 cycles; no cycle has both digits low.
4. digit_en -> 0 mid-SHOW -> outputs all ones within 2 cycles, state IDLE. Set digit_en=2'b01 -> digit 0 driven after a 2-cycle BLANK.
5. Change digit_data[3:0] 3->7 mid-SHOW of digit 0 -> seg shows '7' exactly 1 cycle later, with no dwell restart.
6. Assert reset mid-SHOW -> seg and digit_sel_n all ones in the same cycle, asynchronously. Release -> the scenario 1 sequence repeats exactly.
